counter_display_n: RTL

COUNTER_DISPLAY_N -- requirements
Module: counter_display_n

---
 rtl/counter_display_n.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/counter_display_n.sv
// counter_display_n: prescaled BCD up/down counter with a 7-segment decode per digit.
// The count steps once every TICK_DIV clocks. It can wrap between 0 and LIMIT or
// saturate at either end.
// Optional feature (macro COUNTER_DISPLAY_LOAD_EN): adds a synchronous parallel
// load (ports load, load_value). A load clamps each digit to 9 and the whole
// value to LIMIT.
module counter_display_n #(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 150000000,
    parameter int LIMIT    = 99
) (
    input  logic                  clock,
    input  logic                  n_reset,
    input  logic                  down,
    input  logic                  hold,
    input  logic                  sat,
`ifdef COUNTER_DISPLAY_LOAD_EN
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
`endif
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic [7*DIGITS-1:0]   display,
    output logic                  tick,
    output logic                  wrap
);

    localparam int BW = 4 * DIGITS;
    localparam int PW = $clog2(TICK_DIV);

    // Decimal LIMIT converted to its packed BCD form at elaboration time
    function automatic logic [BW-1:0] to_bcd(input int v);
        logic [BW-1:0] r;
        int            t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [BW-1:0] LIMIT_BCD = to_bcd(LIMIT);
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);

    // Add one in decimal, rippling the carry through every digit
    function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Subtract one in decimal, rippling the borrow through every digit
    function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Saturate a loaded value: each digit to 9, then the whole value to LIMIT.
    // With every digit in 0..9, the unsigned order of the packed BCD matches numeric order.
    function automatic logic [BW-1:0] sat_load(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        end
        if (r > LIMIT_BCD) begin
            r = LIMIT_BCD;
        end
        return r;
    endfunction

    // Active-high segments g..a; any non-decimal digit shows a lone dash
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    logic [PW-1:0] presc;
    logic          at_last;
    logic [BW-1:0] count_nxt;
    logic          wrap_nxt;

    assign at_last = (presc == PRE_LAST);

    // Next count on a step edge. down/hold/sat matter only when the prescaler is at its last value.
    always_comb begin
        count_nxt = count_bcd;
        wrap_nxt  = 1'b0;
        if (at_last && !hold) begin
            if (!down) begin
                if (count_bcd == LIMIT_BCD) begin
                    if (!sat) begin
                        count_nxt = '0;
                        wrap_nxt  = 1'b1;
                    end
                end else begin
                    count_nxt = bcd_inc(count_bcd);
                end
            end else begin
                if (count_bcd == '0) begin
                    if (!sat) begin
                        count_nxt = LIMIT_BCD;
                        wrap_nxt  = 1'b1;
                    end
                end else begin
                    count_nxt = bcd_dec(count_bcd);
                end
            end
        end
    end

    // Prescaler, count and the tick/wrap pulses; a load overrides any step on the same edge
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            presc     <= '0;
            count_bcd <= '0;
            tick      <= 1'b0;
            wrap      <= 1'b0;
        end
`ifdef COUNTER_DISPLAY_LOAD_EN
        else if (load) begin
            presc     <= '0;
            count_bcd <= sat_load(load_value);
            tick      <= 1'b0;
            wrap      <= 1'b0;
        end
`endif
        else begin
            presc     <= at_last ? '0 : presc + PW'(1);
            count_bcd <= count_nxt;
            tick      <= at_last;
            wrap      <= wrap_nxt;
        end
    end

    // Zero-latency segment decode of every digit of the registered count
    always_comb begin
        display = '0;
        for (int i = 0; i < DIGITS; i++) begin
            display[7*i +: 7] = seg7(count_bcd[4*i +: 4]);
        end
    end

endmodule
